// File: rtl/pc_pkg.sv
// Shared types for the fetch program counter: op encoding and the priority decode of the control inputs.
// The optional error-reporting build is selected with the PC_STACK_ERR_EN macro.
package pc_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_SKIP,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_t;

  // Stall beats everything, and call beats ret when both are asserted.
  function automatic pc_op_t pc_decode(
    input logic en,
    input logic call,
    input logic ret,
    input logic sel_pc,
    input logic sel_br
  );
    pc_op_t op;
    op = PC_INC;
    if (!en) begin
      op = PC_HOLD;
    end else if (call) begin
      op = PC_CALL;
    end else if (ret) begin
      op = PC_RET;
    end else if (sel_pc) begin
      op = PC_JUMP;
    end else if (sel_br) begin
      op = PC_SKIP;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO with a wrapping top pointer. With PC_STACK_ERR_EN a push on a full stack is
// dropped; without it the stack is circular and the push overwrites the oldest entry.
module pc_ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_sp,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [SP_W-1:0]  r_sp;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_full   = (r_sp == SP_W'(DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_rd_ptr = r_top - 1'b1;

`ifdef PC_STACK_ERR_EN
  assign w_wr_en = i_push && !w_full;
`else
  // When full, r_top already points at the oldest entry, so writing there overwrites it.
  assign w_wr_en = i_push;
`endif
  assign w_rd_en = i_pop && !i_push && !w_empty;

  // The top entry must be visible in the same cycle a return is decoded.
  assign o_rdata = r_mem[w_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_top] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_top <= '0;
      r_sp  <= '0;
    end else if (w_wr_en) begin
      r_top <= r_top + 1'b1;
      if (!w_full) begin
        r_sp <= r_sp + 1'b1;
      end
    end else if (w_rd_en) begin
      r_top <= w_rd_ptr;
      r_sp  <= r_sp - 1'b1;
    end
  end

  assign o_sp    = r_sp;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/pc_call_stack.sv
// Fetch program counter with stall, jump, skip, call and return. The sticky {overflow, underflow}
// err port exists only when PC_STACK_ERR_EN is defined.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0,
  parameter int SKIP_INC    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sel_pc,
  input  logic                          sel_br,
  input  logic                          call,
  input  logic                          ret,
  input  logic [ADDR_W-1:0]             K,
  output logic [ADDR_W-1:0]             out,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          full,
  output logic                          empty
`ifdef PC_STACK_ERR_EN
  ,
  output logic [1:0]                    err
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  pc_op_t            w_op;

  assign w_op     = pc_decode(en, call, ret, sel_pc, sel_br);
  assign w_pc_inc = r_pc + 1'b1;
  assign w_push   = (w_op == PC_CALL);
  assign w_pop    = (w_op == PC_RET) && !w_empty;

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_pc_inc),
    .o_rdata (w_rdata),
    .o_sp    (sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= ADDR_W'(RESET_VEC);
    end else begin
      case (w_op)
        PC_HOLD: r_pc <= r_pc;
        PC_SKIP: r_pc <= r_pc + ADDR_W'(SKIP_INC);
        PC_JUMP: r_pc <= K;
        PC_CALL: r_pc <= K;
        // A return with nothing on the stack degrades to a plain increment.
        PC_RET:  r_pc <= w_empty ? w_pc_inc : w_rdata;
        default: r_pc <= w_pc_inc;
      endcase
    end
  end

`ifdef PC_STACK_ERR_EN
  logic [1:0] r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 2'b00;
    end else begin
      if (w_op == PC_CALL && w_full) begin
        r_err[1] <= 1'b1;
      end
      if (w_op == PC_RET && w_empty) begin
        r_err[0] <= 1'b1;
      end
    end
  end

  assign err = r_err;
`endif

  assign out   = r_pc;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: queue-based reference model checked every cycle, directed cases with
// literal expectations, then randomized traffic. Honours PC_STACK_ERR_EN like the design.
module tb_pc_call_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       sel_pc = 1'b0;
  logic       sel_br = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] K = 8'h00;
  logic [7:0] out;
  logic [2:0] sp;
  logic       full;
  logic       empty;
`ifdef PC_STACK_ERR_EN
  logic [1:0] err;
`endif

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  pc_call_stack #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (0),
    .SKIP_INC    (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sel_pc (sel_pc),
    .sel_br (sel_br),
    .call   (call),
    .ret    (ret),
    .K      (K),
    .out    (out),
    .sp     (sp),
    .full   (full),
    .empty  (empty)
`ifdef PC_STACK_ERR_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: PC as plain 8-bit arithmetic, stack as a queue of return addresses.
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_stk[$];
  logic [1:0] m_err = 2'b00;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_err = 2'b00;
    end else if (en) begin
      if (call) begin
`ifdef PC_STACK_ERR_EN
        if (m_stk.size() == 4) m_err[1] = 1'b1;
        else m_stk.push_back(m_pc + 8'd1);
`else
        if (m_stk.size() == 4) void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 8'd1);
`endif
        m_pc = K;
      end else if (ret) begin
        if (m_stk.size() == 0) begin
          m_pc = m_pc + 8'd1;
`ifdef PC_STACK_ERR_EN
          m_err[0] = 1'b1;
`endif
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (sel_pc) begin
        m_pc = K;
      end else if (sel_br) begin
        m_pc = m_pc + 8'd2;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Compare every settled cycle against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_out", 32'(out), 32'(m_pc));
      chk("model_sp", 32'(sp), 32'(m_stk.size()));
      chk("model_full", 32'(full), 32'(m_stk.size() == 4));
      chk("model_empty", 32'(empty), 32'(m_stk.size() == 0));
`ifdef PC_STACK_ERR_EN
      chk("model_err", 32'(err), 32'(m_err));
`endif
    end
  end

  task automatic step(input logic r, input logic e, input logic c, input logic rt,
                      input logic sp_i, input logic br, input logic [7:0] k);
    reset = r; en = e; call = c; ret = rt; sel_pc = sp_i; sel_br = br; K = k;
    @(posedge clk);
    @(negedge clk);
    $display("cyc rst=%0b en=%0b call=%0b ret=%0b jmp=%0b br=%0b K=%02h -> out=%02h sp=%0d",
             r, e, c, rt, sp_i, br, k, out, sp);
  endtask

  task automatic idle();
    step(1, 1, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic jump(input logic [7:0] k);
    step(1, 1, 0, 0, 1, 0, k);
  endtask

  logic [7:0] exp_ret[4];

  initial begin
    // Reset then three increments.
    step(0, 0, 0, 0, 0, 0, 8'h00);
    check_en = 1'b1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
`ifdef PC_STACK_ERR_EN
    chk("rst_err", 32'(err), 32'h0);
`endif
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("inc_out", 32'(out), 32'(i));
    end
    chk("inc_sp", 32'(sp), 32'h0);

    // Skip, jump and wrap.
    jump(8'h05);
    step(1, 1, 0, 0, 0, 1, 8'h00);
    chk("skip_out", 32'(out), 32'h07);
    jump(8'h40);
    chk("jump_out", 32'(out), 32'h40);
    jump(8'hFF);
    idle();
    chk("wrap_inc", 32'(out), 32'h00);
    jump(8'hFF);
    step(1, 1, 0, 0, 0, 1, 8'h00);
    chk("wrap_skip", 32'(out), 32'h01);

    // Single call / return.
    jump(8'h10);
    step(1, 1, 1, 0, 0, 0, 8'h80);
    chk("call_out", 32'(out), 32'h80);
    chk("call_sp", 32'(sp), 32'h1);
    step(1, 1, 0, 1, 0, 0, 8'h00);
    chk("ret_out", 32'(out), 32'h11);
    chk("ret_sp", 32'(sp), 32'h0);

    // Stall ignores ops, then call beats ret.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 1, 0, 8'h99);
      chk("stall_out", 32'(out), 32'h11);
      chk("stall_sp", 32'(sp), 32'h0);
    end
    step(1, 1, 1, 1, 0, 0, 8'h55);
    chk("callret_out", 32'(out), 32'h55);
    chk("callret_sp", 32'(sp), 32'h1);

    // Five nested calls into a 4-deep stack.
    step(0, 0, 0, 0, 0, 0, 8'h00);
    jump(8'h10);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0, 0, 8'h20 + 8'(i * 16));
    end
    chk("nest_sp", 32'(sp), 32'h4);
    chk("nest_full", 32'(full), 32'h1);
`ifdef PC_STACK_ERR_EN
    chk("nest_err", 32'(err), 32'h2);
    exp_ret = '{8'h41, 8'h31, 8'h21, 8'h11};
`else
    exp_ret = '{8'h51, 8'h41, 8'h31, 8'h21};
`endif
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 0, 0, 8'h00);
      chk("nest_ret", 32'(out), 32'(exp_ret[i]));
    end
    chk("nest_empty", 32'(empty), 32'h1);

    // Reset aborts a call, then return on empty.
    step(1, 1, 1, 0, 0, 0, 8'h20);
    step(1, 1, 1, 0, 0, 0, 8'h30);
    chk("pre_rst_sp", 32'(sp), 32'h2);
    step(0, 1, 1, 0, 0, 0, 8'h70);
    chk("rstcall_out", 32'(out), 32'h0);
    chk("rstcall_sp", 32'(sp), 32'h0);
`ifdef PC_STACK_ERR_EN
    chk("rstcall_err", 32'(err), 32'h0);
`endif
    step(1, 1, 0, 1, 0, 0, 8'h00);
    chk("uflow_out", 32'(out), 32'h1);
    chk("uflow_sp", 32'(sp), 32'h0);
`ifdef PC_STACK_ERR_EN
    chk("uflow_err", 32'(err), 32'h1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(7) != 0),
           ($urandom_range(4) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(2) == 0),
           8'($urandom));
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
